bcd2421_count_ctrl: RTL and testbench
=====================================

Name: bcd2421_count_ctrl

Overview:
- Controller and sequencer for a cascaded multi-digit 2421-code decade counter.
- Accepts CLEAR/START/STOP/LOAD commands over a valid/ready handshake.
- Paces increments with a prescaler, ripples carries between digits, and compares the count against a loaded 2421 target.
- Sits between a command source (FSM, switch debouncer or CPU register) and a display/decoder stage that consumes the 2421 count.

Parameters:
- NDIG, 2, number of 2421 decade digits (≥1); count/target width = 4*NDIG.
- TICK_DIV, 1, clock cycles per increment while running (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 CLEAR, 01 START, 10 STOP, 11 LOAD.
- cmd_data  in  4*NDIG  LOAD target, 2421 per digit, digit 0 in [3:0].
- count  out  4*NDIG  current count, 2421 per digit.
- running  out  1  high in RUN state.
- done  out  1  one-cycle pulse when count reaches target.
- err  out  1  sticky flag: LOAD with an illegal 2421 code.

Behaviour:
- Legal 2421 digit codes, values 0..9: 0000, 0001, 0010, 0011, 0100, 1011, 1100, 1101, 1110, 1111.
- Digit successor: 0000→0001→0010→0011→0100→1011→1100→1101→1110→1111→0000.
- Reset (rst=0 at an edge) overrides everything, including a simultaneous command:
  - count=0, target=all-1111 (99..9), state IDLE, prescaler=0.
  - running=0, done=0, err=0, cmd_ready=1.
- States: IDLE, RUN, DONE.
- cmd_ready=1 every cycle except the cycle in which done=1.
- Commands take effect at the accepting edge:
  - CLEAR, any state: count=0, err=0, prescaler=0, state→IDLE. Target is kept.
  - START from IDLE: state→RUN, prescaler=0; count is kept, so a STOP/START pair resumes.
  - START from DONE: count=0, prescaler=0, state→RUN.
  - START in RUN: no effect.
  - STOP in RUN: state→IDLE, count held, prescaler=0. STOP in IDLE or DONE: no effect.
  - LOAD, any state, all digits legal: target←cmd_data. State and count are unchanged.
  - LOAD with any illegal digit: target unchanged, err←1.
- Prescaler and ticks:
  - In RUN, the prescaler counts 0..TICK_DIV-1.
  - tick is asserted when prescaler==TICK_DIV-1; the prescaler wraps to 0.
  - The first increment lands exactly TICK_DIV cycles after the START edge.
- Increment on tick:
  - Digit 0 steps.
  - Digit i steps only if all lower digits were 1111 before the tick.
  - All-9s wraps to all-0 with no overflow flag.
- Target compare:
  - Evaluated only on the incremented value, never on a held value.
  - If new count == target: state→DONE, running=0, done=1 for exactly that cycle, count held.
  - Target equal to count at START does not fire until the counter wraps back around.
- A command accepted in the same cycle as a tick takes priority; the tick is discarded.
- count never holds an illegal code.

Decomposition:
- Package bcd2421_pkg: op encodings, state enum, the ten 2421 code constants, function next_2421(d), function is_2421(d).
- One sub-module, bcd2421_digit: 4-bit register with sync clear, step enable and carry_out (= en & digit==1111).
- Instantiate NDIG copies in a generate chain.
- The controller holds the FSM, prescaler, target register and compare.

Test Plan:
- NDIG=2, TICK_DIV=1, reset, START → count=8'h0B after 5 cycles; 8'h10 after 10 cycles; running=1 throughout.
- LOAD 8'h0B, START → done=1 for one cycle on the edge count becomes 8'h0B; cmd_ready=0 that cycle; then running=0 and count holds 8'h0B for 20 cycles.
- LOAD 8'h05 (illegal digit 0101) → err=1 and target unchanged (default target 99 still fires at 8'hFF); CLEAR → err=0, count=0.
- LOAD 8'h00, START from 0 → no done at cycle 0; at tick 100 count wraps 8'hFF→8'h00 and done pulses.
- TICK_DIV=3: START → first increment 3 cycles later; STOP at count 8'h03, idle 10 cycles (count stays 8'h03), START → 8'h04 three cycles later.
- During RUN, rst=0 with simultaneous cmd_valid=1 START → next edge: count=0, IDLE, running=0, done=0, err=0, cmd_ready=1.

Source files
------------

// File: rtl/bcd2421_pkg.sv
// Shared encodings and 2421 digit helpers for the cascaded decade counter.
package bcd2421_pkg;

   typedef enum logic [1:0] {
      OP_CLEAR = 2'b00,
      OP_START = 2'b01,
      OP_STOP  = 2'b10,
      OP_LOAD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [3:0] D0 = 4'b0000;
   localparam logic [3:0] D1 = 4'b0001;
   localparam logic [3:0] D2 = 4'b0010;
   localparam logic [3:0] D3 = 4'b0011;
   localparam logic [3:0] D4 = 4'b0100;
   localparam logic [3:0] D5 = 4'b1011;
   localparam logic [3:0] D6 = 4'b1100;
   localparam logic [3:0] D7 = 4'b1101;
   localparam logic [3:0] D8 = 4'b1110;
   localparam logic [3:0] D9 = 4'b1111;

   // Illegal inputs fall back to zero so a corrupted digit self-heals.
   function automatic logic [3:0] next_2421(input logic [3:0] d);
      logic [3:0] n;
      case (d)
         D0:      n = D1;
         D1:      n = D2;
         D2:      n = D3;
         D3:      n = D4;
         D4:      n = D5;
         D5:      n = D6;
         D6:      n = D7;
         D7:      n = D8;
         D8:      n = D9;
         default: n = D0;
      endcase
      return n;
   endfunction

   function automatic logic is_2421(input logic [3:0] d);
      logic ok;
      case (d)
         D0, D1, D2, D3, D4, D5, D6, D7, D8, D9: ok = 1'b1;
         default:                                 ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/bcd2421_digit.sv
// One 2421 decade digit: sync clear, step on enable, carry when stepping past 9.
module bcd2421_digit
   import bcd2421_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   output logic [3:0] q,
   output logic       carry_out
);

   always_ff @(posedge clk) begin
      if (!rst || clr) q <= D0;
      else if (en)     q <= next_2421(q);
   end

   assign carry_out = en & (q == D9);

endmodule

// File: rtl/bcd2421_count_ctrl.sv
// Command-driven sequencer for an NDIG-digit 2421 counter with prescaled
// stepping and target compare.
module bcd2421_count_ctrl
   import bcd2421_pkg::*;
#(
   parameter int NDIG     = 2,
   parameter int TICK_DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [4*NDIG-1:0] cmd_data,
   output logic [4*NDIG-1:0] count,
   output logic              running,
   output logic              done,
   output logic              err
);

   localparam int W  = 4 * NDIG;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_e          state, state_nx;
   logic [PW-1:0]   presc, presc_nx;
   logic [W-1:0]    target, target_nx;
   logic            err_q, err_nx;
   logic            done_q, done_nx;
   logic            clr_cnt, legal;
   logic [NDIG:0]   en_c;
   logic [W-1:0]    nxt_cnt;
   op_e             op;
   logic            acc, tick, inc, hit;

   assign op        = op_e'(cmd_op);
   assign cmd_ready = ~done_q;
   assign acc       = cmd_valid & cmd_ready;
   assign tick      = (presc == PW'(TICK_DIV - 1));
   // An accepted command swallows the tick that would land on the same edge.
   assign inc       = (state == S_RUN) & tick & ~acc;
   assign en_c[0]   = inc;

   generate
      for (genvar i = 0; i < NDIG; i++) begin : g_dig
         bcd2421_digit u_dig (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr_cnt),
            .en        (en_c[i]),
            .q         (count[4*i +: 4]),
            .carry_out (en_c[i+1])
         );
         assign nxt_cnt[4*i +: 4] = en_c[i] ? next_2421(count[4*i +: 4])
                                            : count[4*i +: 4];
      end
   endgenerate

   // Compare only the freshly incremented value, so a held match never fires.
   assign hit = inc & (nxt_cnt == target);

   always_comb begin
      legal = 1'b1;
      for (int i = 0; i < NDIG; i++)
         legal = legal & is_2421(cmd_data[4*i +: 4]);
   end

   always_comb begin
      state_nx  = state;
      presc_nx  = presc;
      target_nx = target;
      err_nx    = err_q;
      done_nx   = hit;
      clr_cnt   = 1'b0;
      if (state == S_RUN)
         presc_nx = tick ? '0 : presc + PW'(1);
      if (hit)
         state_nx = S_DONE;
      if (acc) begin
         case (op)
            OP_CLEAR: begin
               clr_cnt  = 1'b1;
               err_nx   = 1'b0;
               presc_nx = '0;
               state_nx = S_IDLE;
            end
            OP_START: begin
               if (state != S_RUN) begin
                  state_nx = S_RUN;
                  presc_nx = '0;
                  clr_cnt  = (state == S_DONE);
               end
            end
            OP_STOP: begin
               if (state == S_RUN) begin
                  state_nx = S_IDLE;
                  presc_nx = '0;
               end
            end
            default: begin
               if (legal) target_nx = cmd_data;
               else       err_nx    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         presc  <= '0;
         target <= '1;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         presc  <= presc_nx;
         target <= target_nx;
         err_q  <= err_nx;
         done_q <= done_nx;
      end
   end

   assign running = (state == S_RUN);
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bcd2421_count_ctrl.sv
// Directed bench for the 2421 counter controller, TICK_DIV=1 and TICK_DIV=3 instances.
module tb_bcd2421_count_ctrl;

   localparam logic [1:0] CLR = 2'b00, STA = 2'b01, STP = 2'b10, LOD = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       v1 = 1'b0, v3 = 1'b0;
   logic [1:0] op1 = 2'b00, op3 = 2'b00;
   logic [7:0] d1 = 8'h00, d3 = 8'h00;
   logic       rdy1, rdy3, run1, run3, done1, done3, err1, err3;
   logic [7:0] cnt1, cnt3;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   bcd2421_count_ctrl #(.NDIG(2), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_op(op1),
      .cmd_data(d1), .count(cnt1), .running(run1), .done(done1), .err(err1));

   bcd2421_count_ctrl #(.NDIG(2), .TICK_DIV(3)) dut3 (
      .clk(clk), .rst(rst), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_op(op3),
      .cmd_data(d3), .count(cnt3), .running(run3), .done(done3), .err(err3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cmd1(input logic [1:0] op, input logic [7:0] d);
      v1 = 1'b1; op1 = op; d1 = d;
      step();
      v1 = 1'b0;
   endtask

   task automatic cmd3(input logic [1:0] op, input logic [7:0] d);
      v3 = 1'b1; op3 = op; d3 = d;
      step();
      v3 = 1'b0;
   endtask

   initial begin
      step(2);
      rst = 1'b1;
      chk("rst_count", 32'(cnt1), 32'h00);
      chk("rst_running", 32'(run1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_err", 32'(err1), 32'd0);
      chk("rst_ready", 32'(rdy1), 32'd1);

      // counting: 5 -> 0x0B, 10 -> 0x10
      cmd1(STA, 8'h00);
      chk("start_count", 32'(cnt1), 32'h00);
      chk("start_running", 32'(run1), 32'd1);
      step(5);
      chk("cnt5", 32'(cnt1), 32'h0B);
      chk("run5", 32'(run1), 32'd1);
      step(5);
      chk("cnt10", 32'(cnt1), 32'h10);
      chk("run10", 32'(run1), 32'd1);
      step(9);
      chk("cnt19", 32'(cnt1), 32'h1F);
      step(1);
      chk("cnt20_carry", 32'(cnt1), 32'h20);

      // target 0x0B fires and holds
      cmd1(STP, 8'h00);
      cmd1(CLR, 8'h00);
      chk("clr_count", 32'(cnt1), 32'h00);
      cmd1(LOD, 8'h0B);
      cmd1(STA, 8'h00);
      step(4);
      chk("tgt_cnt4", 32'(cnt1), 32'h04);
      chk("tgt_nodone4", 32'(done1), 32'd0);
      step(1);
      chk("tgt_cnt5", 32'(cnt1), 32'h0B);
      chk("tgt_done", 32'(done1), 32'd1);
      chk("tgt_ready0", 32'(rdy1), 32'd0);
      chk("tgt_run0", 32'(run1), 32'd0);
      step(1);
      chk("tgt_done_off", 32'(done1), 32'd0);
      chk("tgt_ready1", 32'(rdy1), 32'd1);
      step(19);
      chk("tgt_hold", 32'(cnt1), 32'h0B);
      chk("tgt_hold_run", 32'(run1), 32'd0);
      chk("tgt_hold_done", 32'(done1), 32'd0);

      // illegal load: err set, default target 99 still applies
      rst = 1'b0; step(); rst = 1'b1;
      cmd1(LOD, 8'h05);
      chk("ill_err", 32'(err1), 32'd1);
      cmd1(STA, 8'h00);
      step(98);
      chk("ill_cnt98", 32'(cnt1), 32'hFE);
      chk("ill_nodone98", 32'(done1), 32'd0);
      step(1);
      chk("ill_cnt99", 32'(cnt1), 32'hFF);
      chk("ill_done99", 32'(done1), 32'd1);
      step(1);
      cmd1(CLR, 8'h00);
      chk("clr_err", 32'(err1), 32'd0);
      chk("clr_count2", 32'(cnt1), 32'h00);

      // target equal to start count fires only after wrap
      cmd1(LOD, 8'h00);
      cmd1(STA, 8'h00);
      chk("wrap_nodone0", 32'(done1), 32'd0);
      step(1);
      chk("wrap_cnt1", 32'(cnt1), 32'h01);
      chk("wrap_nodone1", 32'(done1), 32'd0);
      step(98);
      chk("wrap_cnt99", 32'(cnt1), 32'hFF);
      chk("wrap_nodone99", 32'(done1), 32'd0);
      step(1);
      chk("wrap_cnt100", 32'(cnt1), 32'h00);
      chk("wrap_done100", 32'(done1), 32'd1);
      step(1);

      // reset during RUN beats a simultaneous START
      cmd1(LOD, 8'hA0);
      chk("ill2_err", 32'(err1), 32'd1);
      cmd1(STA, 8'h00);
      chk("restart_cnt", 32'(cnt1), 32'h00);
      step(3);
      chk("restart_cnt3", 32'(cnt1), 32'h03);
      rst = 1'b0; v1 = 1'b1; op1 = STA;
      step(1);
      chk("rrun_count", 32'(cnt1), 32'h00);
      chk("rrun_running", 32'(run1), 32'd0);
      chk("rrun_done", 32'(done1), 32'd0);
      chk("rrun_err", 32'(err1), 32'd0);
      chk("rrun_ready", 32'(rdy1), 32'd1);
      rst = 1'b1; v1 = 1'b0;
      step(2);
      chk("rrun_idle_cnt", 32'(cnt1), 32'h00);

      // TICK_DIV=3 pacing, STOP/START resume
      cmd3(STA, 8'h00);
      step(2);
      chk("td3_cnt_e2", 32'(cnt3), 32'h00);
      step(1);
      chk("td3_cnt_e3", 32'(cnt3), 32'h01);
      step(6);
      chk("td3_cnt_e9", 32'(cnt3), 32'h03);
      cmd3(STP, 8'h00);
      chk("td3_stop_run", 32'(run3), 32'd0);
      step(10);
      chk("td3_hold", 32'(cnt3), 32'h03);
      cmd3(STA, 8'h00);
      step(2);
      chk("td3_resume_e2", 32'(cnt3), 32'h03);
      step(1);
      chk("td3_resume_e3", 32'(cnt3), 32'h04);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
